// File: rtl/mux_arbiter_if.sv
// Request/grant and data bus between two requesters and the shared-port arbiter.
// The arbiter attaches through the slave modport, requesters through master.
interface mux_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             reqA;
    logic             reqB;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             gntA;
    logic             gntB;
    logic             sel;
    logic             valid;
    logic [WIDTH-1:0] out;

    modport master (
        output reqA, reqB, inA, inB,
        input  gntA, gntB, sel, valid, out
    );

    modport slave (
        input  reqA, reqB, inA, inB,
        output gntA, gntB, sel, valid, out
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 data mux,
// with a bounded hold time for the owner while the other side is waiting.
//
// state   | meaning
// IDLE    | no owner; sel keeps its last value
// GRANT_A | requester A owns the port (sel = 0)
// GRANT_B | requester B owns the port (sel = 1)
module mux_arbiter #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic clock,
    input  logic reset,
    mux_arbiter_if.slave bus
);
    localparam logic [3:0] HOLD = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t     state;
    logic       last;
    logic [3:0] count;
    logic [WIDTH-1:0] mux_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bus.gntA <= 1'b0;
            bus.gntB <= 1'b0;
            bus.sel  <= 1'b0;
            last     <= 1'b1;
            count    <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    // On a tie, the side that was not granted last wins.
                    if (bus.reqA && (!bus.reqB || last)) begin
                        state <= GRANT_A; bus.gntA <= 1'b1; bus.gntB <= 1'b0;
                        bus.sel <= 1'b0; last <= 1'b0; count <= 4'd1;
                    end else if (bus.reqB) begin
                        state <= GRANT_B; bus.gntA <= 1'b0; bus.gntB <= 1'b1;
                        bus.sel <= 1'b1; last <= 1'b1; count <= 4'd1;
                    end
                end
                GRANT_A: begin
                    if (bus.reqB && (!bus.reqA || count == HOLD)) begin
                        state <= GRANT_B; bus.gntA <= 1'b0; bus.gntB <= 1'b1;
                        bus.sel <= 1'b1; last <= 1'b1; count <= 4'd1;
                    end else if (!bus.reqA) begin
                        state <= IDLE; bus.gntA <= 1'b0; bus.gntB <= 1'b0;
                        count <= 4'd0;
                    end else if (count != HOLD) begin
                        count <= count + 4'd1;
                    end
                end
                GRANT_B: begin
                    if (bus.reqA && (!bus.reqB || count == HOLD)) begin
                        state <= GRANT_A; bus.gntA <= 1'b1; bus.gntB <= 1'b0;
                        bus.sel <= 1'b0; last <= 1'b0; count <= 4'd1;
                    end else if (!bus.reqB) begin
                        state <= IDLE; bus.gntA <= 1'b0; bus.gntB <= 1'b0;
                        count <= 4'd0;
                    end else if (count != HOLD) begin
                        count <= count + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE; bus.gntA <= 1'b0; bus.gntB <= 1'b0;
                    count <= 4'd0;
                end
            endcase
        end
    end

    assign mux_out   = bus.sel ? bus.inB : bus.inA;
    assign bus.out   = mux_out;
    assign bus.valid = bus.gntA | bus.gntB;
endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: table of per-cycle vectors with a scoreboard queue, plus
// contention runs against a MAX_HOLD=4 and a MAX_HOLD=1 instance.
module tb_mux_arbiter;
    typedef struct {
        logic        rst;
        logic        ra;
        logic        rb;
        logic [15:0] ia;
        logic [15:0] ib;
        logic        ga;
        logic        gb;
        logic        sel;
        logic [15:0] out;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    vec_t vecs[$];
    vec_t exp_q[$];
    logic exp2_q[$];

    mux_arbiter_if #(.WIDTH(16)) bus1 ();
    mux_arbiter_if #(.WIDTH(16)) bus2 ();

    assign bus2.reqA = bus1.reqA;
    assign bus2.reqB = bus1.reqB;
    assign bus2.inA  = bus1.inA;
    assign bus2.inB  = bus1.inB;

    mux_arbiter #(.WIDTH(16), .MAX_HOLD(4)) dut1 (.clock(clk), .reset(reset), .bus(bus1));
    mux_arbiter #(.WIDTH(16), .MAX_HOLD(1)) dut2 (.clock(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic ra, logic rb, logic [15:0] ia,
                                logic [15:0] ib, logic ga, logic gb, logic sel,
                                logic [15:0] out);
        vec_t v;
        v.rst = rst; v.ra = ra; v.rb = rb; v.ia = ia; v.ib = ib;
        v.ga = ga; v.gb = gb; v.sel = sel; v.out = out;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        @(negedge clk);
        reset     = v.rst;
        bus1.reqA = v.ra;
        bus1.reqB = v.rb;
        bus1.inA  = v.ia;
        bus1.inB  = v.ib;
        exp_q.push_back(v);
    endtask

    task automatic compare(string tag);
        vec_t e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " gntA"}, 32'(bus1.gntA), 32'(e.ga));
        check({tag, " gntB"}, 32'(bus1.gntB), 32'(e.gb));
        check({tag, " sel"}, 32'(bus1.sel), 32'(e.sel));
        check({tag, " valid"}, 32'(bus1.valid), 32'(e.ga | e.gb));
        if (e.ga | e.gb)
            check({tag, " out"}, 32'(bus1.out), 32'(e.out));
    endtask

    localparam logic [15:0] DA = 16'hAAAA;
    localparam logic [15:0] DB = 16'h5555;

    initial begin
        reset = 1'b1;
        bus1.reqA = 1'b0; bus1.reqB = 1'b0;
        bus1.inA = '0; bus1.inB = '0;

        // reset held with both requesting, then the tie goes to A
        vecs.push_back(mk(1, 1, 1, DA, DB, 0, 0, 0, 16'h0));
        vecs.push_back(mk(1, 1, 1, DA, DB, 0, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, DA, DB, 1, 0, 0, DA));
        vecs.push_back(mk(0, 0, 0, DA, DB, 0, 0, 0, 16'h0));
        // single requester, longer than MAX_HOLD
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 1, 0, 16'h1234, DB, 1, 0, 0, 16'h1234));
        vecs.push_back(mk(0, 0, 0, 16'h1234, DB, 0, 0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 0, 16'h1234, DB, 0, 0, 0, 16'h0));
        // handoff with no gap
        vecs.push_back(mk(0, 1, 0, DA, DB, 1, 0, 0, DA));
        vecs.push_back(mk(0, 1, 1, DA, DB, 1, 0, 0, DA));
        vecs.push_back(mk(0, 0, 1, DA, DB, 0, 1, 1, DB));
        vecs.push_back(mk(0, 0, 1, DA, DB, 0, 1, 1, DB));
        // idle keeps sel, then tie goes to A since B was last
        vecs.push_back(mk(0, 0, 0, DA, DB, 0, 0, 1, 16'h0));
        vecs.push_back(mk(0, 0, 0, DA, DB, 0, 0, 1, 16'h0));
        vecs.push_back(mk(0, 1, 1, DA, DB, 1, 0, 0, DA));
        // B held two cycles, then mid-grant reset
        vecs.push_back(mk(0, 0, 1, DA, DB, 0, 1, 1, DB));
        vecs.push_back(mk(0, 0, 1, DA, DB, 0, 1, 1, DB));
        vecs.push_back(mk(1, 1, 1, DA, DB, 0, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, DA, DB, 1, 0, 0, DA));
        vecs.push_back(mk(0, 0, 0, DA, DB, 0, 0, 0, 16'h0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            compare($sformatf("vec%0d", i));
        end

        // continuous contention after reset
        drive(mk(1, 0, 0, DA, DB, 0, 0, 0, 16'h0));
        compare("cont_reset");
        for (int k = 0; k < 20; k++) begin
            logic ga;
            ga = ((k / 4) % 2) == 0;
            drive(mk(0, 1, 1, DA, DB, ga, !ga, !ga, ga ? DA : DB));
            exp2_q.push_back((k % 2) == 1);
            compare($sformatf("cont%0d", k));
            begin
                logic e2;
                e2 = exp2_q.pop_front();
                check($sformatf("hold1_%0d gntB", k), 32'(bus2.gntB), 32'(e2));
                check($sformatf("hold1_%0d gntA", k), 32'(bus2.gntA), 32'(!e2));
                check($sformatf("excl%0d", k), 32'(bus1.gntA & bus1.gntB), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
